aes_key_schedule: RTL

Parametrised AES key schedule for the lab7 AES datapath. It supports AES-128, AES-192 and AES-256 through one parameter. On a `load` pulse it expands the cipher key into all round keys, one 32-bit word per cycle, and stores them in an internal word buffer. After expansion, the cipher core reads any round key by index in either order, so encrypt and decrypt cores share one block.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_sbox.sv | 36 +++
 rtl/aes_key_schedule.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and helpers for the AES datapath and its key schedule:
//   word_t     32-bit schedule word
//   state_e    key-schedule FSM states
//   RCON_INIT  first round constant
//   xtime      multiply-by-x in GF(2^8), used to advance the round constant
//   nr_of/nw_of  round count and schedule length for a given key length NK
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int nw_of(input int nk);
        return 4 * (nk + 7);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box (SubBytes on a single byte). Shared with the
// cipher core's SubBytes stage.
// Ports:
//   in_byte   in   8  input byte
//   out_byte  out  8  substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Element 0 sits in the most significant byte of the packed constant.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_schedule.sv
// ---------------------------------------------------------------------------
// aes_key_schedule
// Expands an AES-128/192/256 cipher key into the full round-key schedule, one
// 32-bit word per cycle, and serves round keys by index with a one-cycle
// registered read.
// Parameters:
//   NK        key length in 32-bit words (4, 6 or 8)
// Ports:
//   int_osc   in   1       clock, rising edge
//   reset     in   1       synchronous active-low reset
//   load      in   1       capture key and (re)start expansion
//   key       in   32*NK   cipher key, w0 in the most significant word
//   busy      out  1       expansion in progress
//   done      out  1       schedule complete and valid
//   rd_round  in   4       round-key index 0..NR
//   rd_key    out  128     {w[4r], w[4r+1], w[4r+2], w[4r+3]}, registered
//   rd_valid  out  1       rd_key valid for the rd_round of the previous cycle
// ---------------------------------------------------------------------------
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic              int_osc,
    input  logic              reset,
    input  logic              load,
    input  logic [32*NK-1:0]  key,
    output logic              busy,
    output logic              done,
    input  logic [3:0]        rd_round,
    output logic [127:0]      rd_key,
    output logic              rd_valid
);

    localparam int NR = nr_of(NK);
    localparam int NW = nw_of(NK);
    localparam int IW = $clog2(NW);

    generate
        if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
            $error("aes_key_schedule: NK must be 4, 6 or 8");
        end
    endgenerate

    genvar gi;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [IW-1:0]  i_q, i_d;
    logic [2:0]     p_q, p_d;
    logic [7:0]     rcon_q, rcon_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rd_valid_q, rd_valid_d;
    logic [127:0]   rd_key_q, rd_key_d;

    // Word buffer, held in flops and never reset.
    word_t          w_q [NW];
    word_t          w_d [NW];

    // ------------------------------------------------------------------
    // Expansion datapath: w[i] = w[i-NK] ^ f(w[i-1])
    // ------------------------------------------------------------------
    word_t          prev_word;
    word_t          back_word;
    word_t          sub_in;
    word_t          sub_out;
    word_t          temp;
    word_t          new_word;
    logic           wr_en;
    logic           last_word;

    always_comb begin
        prev_word = w_q[i_q - IW'(1)];
        back_word = w_q[i_q - IW'(NK)];
        // RotWord only applies at the start of each NK-word group.
        sub_in    = (p_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    end

    for (gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*gi +: 8]),
            .out_byte (sub_out[8*gi +: 8])
        );
    end

    always_comb begin
        temp = prev_word;
        if (p_q == 3'd0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && p_q == 3'd4) begin
            // AES-256 adds a plain SubWord halfway through each 8-word group.
            temp = sub_out;
        end
        new_word  = back_word ^ temp;
        last_word = (i_q == IW'(NW - 1));
    end

    // ------------------------------------------------------------------
    // Control: FSM and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        p_d     = p_q;
        rcon_d  = rcon_q;
        wr_en   = 1'b0;

        if (load) begin
            // A load in any state restarts from the new key.
            state_d = EXPAND;
            i_d     = IW'(NK);
            p_d     = 3'd0;
            rcon_d  = RCON_INIT;
        end else if (state_q == EXPAND) begin
            wr_en = 1'b1;
            i_d   = i_q + IW'(1);
            // p tracks i mod NK by wrapping instead of dividing; rcon
            // advances on the same wrap so it is ready at the next p==0.
            if (p_q == 3'(NK - 1)) begin
                p_d    = 3'd0;
                rcon_d = xtime(rcon_q);
            end else begin
                p_d = p_q + 3'd1;
            end
            if (last_word) begin
                state_d = DONE;
            end
        end

        // Flags follow the registered state one cycle later, so they are
        // mutually exclusive and done appears NW-NK+1 cycles after load.
        busy_d = (state_q == EXPAND);
        done_d = (state_q == DONE);
    end

    // ------------------------------------------------------------------
    // Buffer write: parallel key load, then one word per EXPAND cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_d = w_q;
        if (load) begin
            for (int k = 0; k < NK; k++) begin
                w_d[k] = key[32*(NK-k)-1 -: 32];
            end
        end else if (wr_en) begin
            w_d[i_q] = new_word;
        end
    end

    // ------------------------------------------------------------------
    // Read port: registered, one request per cycle, sees pre-edge state
    // ------------------------------------------------------------------
    always_comb begin
        rd_key_d   = '0;
        rd_valid_d = (state_q == DONE) && (rd_round <= 4'(NR));
        if (rd_round <= 4'(NR)) begin
            for (int k = 0; k < 4; k++) begin
                rd_key_d[127-32*k -: 32] = w_q[{rd_round, 2'(k)}];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge int_osc) begin
        if (!reset) begin
            state_q    <= IDLE;
            i_q        <= IW'(NK);
            p_q        <= 3'd0;
            rcon_q     <= RCON_INIT;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_key_q   <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            p_q        <= p_d;
            rcon_q     <= rcon_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_key_q   <= rd_key_d;
        end
    end

    always_ff @(posedge int_osc) begin
        w_q <= w_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_key   = rd_key_q;
    assign rd_valid = rd_valid_q;

endmodule
